// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and sweep FSM state type for the 2R1W register file
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} sweep_state_t;
endpackage

// File: rtl/regfile_sweep_fsm.sv
// regfile_sweep_fsm: flush sequencer that walks every index once, driving zero-writes into the array
module regfile_sweep_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              flush_req,
    output logic              busy,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_addr
);
    sweep_state_t      r_state;
    sweep_state_t      w_next;
    logic [ADDR_W-1:0] r_cnt;

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) w_next = flush_req ? SWEEP : IDLE;
        else w_next = (r_cnt == '1) ? IDLE : SWEEP;
    end

    // counter wraps to 0 on the final increment, so it is ready for the next flush
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == SWEEP) ? r_cnt + 1'b1 : '0;
        end
    end

    assign busy       = (r_state == SWEEP);
    assign sweep_en   = (r_state == SWEEP);
    assign sweep_addr = r_cnt;
endmodule

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: 2 registered read ports, 1 write port with bypass, hardware flush.
// REGFILE_R0_ZERO_EN makes index 0 a hardwired zero.
module register_file_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_a,
    output logic              rd_valid_b,
    input  logic              flush_req,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_busy;
    logic              w_sweep_en;
    logic [ADDR_W-1:0] w_sweep_addr;
    logic              w_wr_acc;

    regfile_sweep_fsm #(.ADDR_W(ADDR_W)) u_sweep (
        .clk        (clk),
        .clear_n    (clear_n),
        .flush_req  (flush_req),
        .busy       (w_busy),
        .sweep_en   (w_sweep_en),
        .sweep_addr (w_sweep_addr)
    );

`ifdef REGFILE_R0_ZERO_EN
    // index 0 is never written, so its storage stays constant zero
    assign w_wr_acc = wr_en && !w_busy && (wr_addr != '0);
`else
    assign w_wr_acc = wr_en && !w_busy;
`endif

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_sweep_en) begin
            r_mem[w_sweep_addr] <= '0;
        end else if (w_wr_acc) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) rd_data_a <= (w_wr_acc && wr_addr == rd_addr_a) ? wr_data : r_mem[rd_addr_a];
            if (rd_en_b) rd_data_b <= (w_wr_acc && wr_addr == rd_addr_b) ? wr_data : r_mem[rd_addr_b];
        end
    end

    assign busy = w_busy;
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb_register_file_2r1w: directed self-checking bench for register_file_2r1w
module tb_register_file_2r1w;
    logic        clk = 1'b0;
    logic        clear_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en_a, rd_en_b;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        flush_req;
    logic        busy;
    int          checks = 0;
    int          errors = 0;

    register_file_2r1w dut (
        .clk(clk), .clear_n(clear_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
        .flush_req(flush_req), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_en_a = 0; rd_addr_a = 0; rd_en_b = 0; rd_addr_b = 0;
        flush_req = 0;
    endtask

    task automatic test_reset();
        clear_n = 0;
        idle_inputs();
        #3;
        checks++;
        if ({rd_data_a, rd_data_b} !== 64'h0 || {rd_valid_a, rd_valid_b, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset: a=%h b=%h va=%b vb=%b busy=%b required all 0", rd_data_a, rd_data_b, rd_valid_a, rd_valid_b, busy);
        end
        tick();
        clear_n = 1;
        tick();
    endtask

    task automatic test_read_zero();
        rd_en_a = 1; rd_addr_a = 5; rd_en_b = 1; rd_addr_b = 9;
        tick();
        checks++;
        if (rd_data_a !== 0 || rd_data_b !== 0 || rd_valid_a !== 1 || rd_valid_b !== 1) begin
            errors++;
            $display("FAIL read_zero: a=%h b=%h va=%b vb=%b required 0 0 1 1", rd_data_a, rd_data_b, rd_valid_a, rd_valid_b);
        end
        rd_en_a = 0; rd_en_b = 0;
        tick();
        checks++;
        if (rd_valid_a !== 0 || rd_valid_b !== 0) begin
            errors++;
            $display("FAIL valid_drop: va=%b vb=%b required 0 0", rd_valid_a, rd_valid_b);
        end
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 0; rd_en_a = 1; rd_addr_a = 3;
        tick();
        checks++;
        if (rd_data_a !== 32'hDEADBEEF || rd_valid_a !== 1) begin
            errors++;
            $display("FAIL write_read: a=%h va=%b required deadbeef 1", rd_data_a, rd_valid_a);
        end
        rd_en_a = 0; rd_addr_a = 4;
        tick();
        checks++;
        if (rd_data_a !== 32'hDEADBEEF || rd_valid_a !== 0) begin
            errors++;
            $display("FAIL hold: a=%h va=%b required deadbeef 0", rd_data_a, rd_valid_a);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 7; wr_data = 32'h12345678;
        rd_en_a = 1; rd_addr_a = 7; rd_en_b = 1; rd_addr_b = 7;
        tick();
        checks++;
        if (rd_data_a !== 32'h12345678 || rd_data_b !== 32'h12345678) begin
            errors++;
            $display("FAIL bypass_both: a=%h b=%h required 12345678", rd_data_a, rd_data_b);
        end
        wr_addr = 8; wr_data = 32'hCAFEF00D; rd_addr_a = 7; rd_addr_b = 3;
        tick();
        checks++;
        if (rd_data_a !== 32'h12345678 || rd_data_b !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_miss: a=%h b=%h required 12345678 deadbeef", rd_data_a, rd_data_b);
        end
        wr_en = 0; rd_addr_a = 8; rd_addr_b = 8;
        tick();
        checks++;
        if (rd_data_a !== 32'hCAFEF00D || rd_data_b !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL same_index: a=%h b=%h required cafef00d", rd_data_a, rd_data_b);
        end
        rd_en_a = 0; rd_en_b = 0;
    endtask

    task automatic test_flush();
        int n;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = 32'(i + 1);
            tick();
        end
        wr_en = 0;
        for (int i = 0; i < 16; i++) begin
            rd_en_a = 1; rd_addr_a = 4'(i); rd_en_b = 1; rd_addr_b = 4'(15 - i);
            tick();
            checks++;
            if (rd_data_a !== 32'(i + 1) || rd_data_b !== 32'(16 - i)) begin
                errors++;
                $display("FAIL fill[%0d]: a=%h b=%h required %h %h", i, rd_data_a, rd_data_b, i + 1, 16 - i);
            end
        end
        rd_en_a = 0; rd_en_b = 0;
        flush_req = 1;
        tick();
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            wr_en = 1; wr_addr = 4'(n); wr_data = 32'hBAD00000 | 32'(n);
            rd_en_a = 1; rd_addr_a = 4'(n); rd_en_b = 1; rd_addr_b = 4'(n + 15);
            tick();
            checks++;
            if (rd_data_a !== 32'(n + 1) || rd_data_b !== ((n == 0) ? 32'd16 : 32'd0)) begin
                errors++;
                $display("FAIL sweep_read[%0d]: a=%h b=%h required %h %h", n, rd_data_a, rd_data_b, n + 1, (n == 0) ? 16 : 0);
            end
            n++;
        end
        idle_inputs();
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL busy_len: got %0d cycles required 16", n);
        end
        tick();
        checks++;
        if (busy !== 0) begin
            errors++;
            $display("FAIL no_requeue: busy=%b required 0", busy);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en_a = 1; rd_addr_a = 4'(i);
            tick();
            checks++;
            if (rd_data_a !== 0) begin
                errors++;
                $display("FAIL flushed[%0d]: a=%h required 0", i, rd_data_a);
            end
        end
        rd_en_a = 0;
    endtask

    task automatic test_flush_write();
        int n;
        wr_en = 1; wr_addr = 5; wr_data = 32'h55; flush_req = 1;
        tick();
        wr_en = 0; flush_req = 0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL flush_write_len: got %0d required 16", n);
        end
        wr_en = 1; wr_addr = 6; wr_data = 32'h66; rd_en_a = 1; rd_addr_a = 5;
        tick();
        wr_en = 0; rd_addr_a = 6;
        checks++;
        if (rd_data_a !== 0) begin
            errors++;
            $display("FAIL flush_write: a=%h required 0", rd_data_a);
        end
        tick();
        checks++;
        if (rd_data_a !== 32'h66) begin
            errors++;
            $display("FAIL post_flush_write: a=%h required 66", rd_data_a);
        end
        rd_en_a = 0;
    endtask

    task automatic test_reset_mid_sweep();
        wr_en = 1; wr_addr = 10; wr_data = 32'h77;
        tick();
        wr_en = 0; flush_req = 1;
        tick();
        flush_req = 0; rd_en_a = 1; rd_addr_a = 10; rd_en_b = 1; rd_addr_b = 10;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (busy !== 1 || rd_data_a !== 32'h77) begin
            errors++;
            $display("FAIL pre_abort: busy=%b a=%h required 1 77", busy, rd_data_a);
        end
        clear_n = 0;
        #2;
        checks++;
        if (busy !== 0 || rd_data_a !== 0 || rd_data_b !== 0 || rd_valid_a !== 0 || rd_valid_b !== 0) begin
            errors++;
            $display("FAIL abort: busy=%b a=%h b=%h va=%b vb=%b required all 0", busy, rd_data_a, rd_data_b, rd_valid_a, rd_valid_b);
        end
        idle_inputs();
        #1;
        clear_n = 1;
        tick();
        wr_en = 1; wr_addr = 2; wr_data = 32'hA5A5A5A5;
        tick();
        wr_en = 0; rd_en_a = 1; rd_addr_a = 2; rd_en_b = 1; rd_addr_b = 10;
        tick();
        checks++;
        if (rd_data_a !== 32'hA5A5A5A5 || rd_data_b !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL after_abort: a=%h b=%h busy=%b required a5a5a5a5 0 0", rd_data_a, rd_data_b, busy);
        end
        rd_en_a = 0; rd_en_b = 0;
    endtask

    task automatic test_r0();
        logic [31:0] exp;
`ifdef REGFILE_R0_ZERO_EN
        exp = 32'h0;
`else
        exp = 32'hFFFFFFFF;
`endif
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rd_en_a = 1; rd_addr_a = 0;
        tick();
        wr_en = 0;
        checks++;
        if (rd_data_a !== exp) begin
            errors++;
            $display("FAIL r0_same: a=%h required %h", rd_data_a, exp);
        end
        rd_en_b = 1; rd_addr_b = 0;
        tick();
        checks++;
        if (rd_data_a !== exp || rd_data_b !== exp) begin
            errors++;
            $display("FAIL r0_next: a=%h b=%h required %h", rd_data_a, rd_data_b, exp);
        end
        rd_en_a = 0; rd_en_b = 0;
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_write_read();
        test_bypass();
        test_flush();
        test_flush_write();
        test_reset_mid_sweep();
        test_r0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
